// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register: carries EX results into MEM. It also holds the
// madd/msub partial product across EX stalls and counts the instructions that retire into MEM.
module ex_mem_reg #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int CW  = 2,
    parameter int PCW = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            ex_stall,
    input  logic            mem_stall,
    input  logic            ex_valid,
    input  logic [AW-1:0]   ex_wd,
    input  logic            ex_wreg,
    input  logic [DW-1:0]   ex_wdata,
    input  logic            ex_whilo,
    input  logic [DW-1:0]   ex_hi,
    input  logic [DW-1:0]   ex_lo,
    input  logic [2*DW-1:0] ex_hilo_tmp,
    input  logic [CW-1:0]   ex_cnt,
    output logic            mem_valid,
    output logic [AW-1:0]   mem_wd,
    output logic            mem_wreg,
    output logic [DW-1:0]   mem_wdata,
    output logic            mem_whilo,
    output logic [DW-1:0]   mem_hi,
    output logic [DW-1:0]   mem_lo,
    output logic [2*DW-1:0] hilo_tmp_o,
    output logic [CW-1:0]   cnt_o,
    output logic [PCW-1:0]  instr_cnt
);

    logic            valid_q,    valid_d;
    logic [AW-1:0]   wd_q,       wd_d;
    logic            wreg_q,     wreg_d;
    logic [DW-1:0]   wdata_q,    wdata_d;
    logic            whilo_q,    whilo_d;
    logic [DW-1:0]   hi_q,       hi_d;
    logic [DW-1:0]   lo_q,       lo_d;
    logic [2*DW-1:0] hilo_tmp_q, hilo_tmp_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [PCW-1:0]  icnt_q,     icnt_d;

    always_comb begin
        valid_d    = valid_q;
        wd_d       = wd_q;
        wreg_d     = wreg_q;
        wdata_d    = wdata_q;
        whilo_d    = whilo_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        hilo_tmp_d = hilo_tmp_q;
        cnt_d      = cnt_q;
        icnt_d     = icnt_q;

        if (flush) begin
            valid_d    = 1'b0;
            wd_d       = '0;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            whilo_d    = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
            hilo_tmp_d = '0;
            cnt_d      = '0;
        end else if (mem_stall) begin
            // Hold everything; an EX payload offered here (illegal ex_stall=0) is dropped.
        end else if (ex_stall) begin
            // Bubble must be all-zero since MEM/WB act on wreg/whilo directly.
            valid_d    = 1'b0;
            wd_d       = '0;
            wreg_d     = 1'b0;
            wdata_d    = '0;
            whilo_d    = 1'b0;
            hi_d       = '0;
            lo_d       = '0;
            hilo_tmp_d = ex_hilo_tmp;
            cnt_d      = ex_cnt;
        end else begin
            valid_d    = ex_valid;
            wd_d       = ex_wd;
            wreg_d     = ex_wreg;
            wdata_d    = ex_wdata;
            whilo_d    = ex_whilo;
            hi_d       = ex_hi;
            lo_d       = ex_lo;
            hilo_tmp_d = '0;
            cnt_d      = '0;
            if (ex_valid) begin
                icnt_d = icnt_q + PCW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q    <= 1'b0;
            wd_q       <= '0;
            wreg_q     <= 1'b0;
            wdata_q    <= '0;
            whilo_q    <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            hilo_tmp_q <= '0;
            cnt_q      <= '0;
            icnt_q     <= '0;
        end else begin
            valid_q    <= valid_d;
            wd_q       <= wd_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            whilo_q    <= whilo_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            hilo_tmp_q <= hilo_tmp_d;
            cnt_q      <= cnt_d;
            icnt_q     <= icnt_d;
        end
    end

    assign mem_valid  = valid_q;
    assign mem_wd     = wd_q;
    assign mem_wreg   = wreg_q;
    assign mem_wdata  = wdata_q;
    assign mem_whilo  = whilo_q;
    assign mem_hi     = hi_q;
    assign mem_lo     = lo_q;
    assign hilo_tmp_o = hilo_tmp_q;
    assign cnt_o      = cnt_q;
    assign instr_cnt  = icnt_q;

endmodule

// File: tb/tb_ex_mem_reg.sv
// Bench for ex_mem_reg (PCW=4 so the instruction counter wrap is reachable):
// table vectors with hand-derived expectations plus a reference-model scoreboard.
module tb_ex_mem_reg;

    logic        clk = 1'b0;
    logic        rst, flush, ex_stall, mem_stall, ex_valid, ex_wreg, ex_whilo;
    logic [4:0]  ex_wd;
    logic [31:0] ex_wdata, ex_hi, ex_lo;
    logic [63:0] ex_hilo_tmp;
    logic [1:0]  ex_cnt;
    logic        mem_valid, mem_wreg, mem_whilo;
    logic [4:0]  mem_wd;
    logic [31:0] mem_wdata, mem_hi, mem_lo;
    logic [63:0] hilo_tmp_o;
    logic [1:0]  cnt_o;
    logic [3:0]  instr_cnt;

    always #5 clk = ~clk;

    ex_mem_reg #(.DW(32), .AW(5), .CW(2), .PCW(4)) dut (
        .clk(clk), .rst(rst), .flush(flush), .ex_stall(ex_stall), .mem_stall(mem_stall),
        .ex_valid(ex_valid), .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata),
        .ex_whilo(ex_whilo), .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_hilo_tmp(ex_hilo_tmp),
        .ex_cnt(ex_cnt), .mem_valid(mem_valid), .mem_wd(mem_wd), .mem_wreg(mem_wreg),
        .mem_wdata(mem_wdata), .mem_whilo(mem_whilo), .mem_hi(mem_hi), .mem_lo(mem_lo),
        .hilo_tmp_o(hilo_tmp_o), .cnt_o(cnt_o), .instr_cnt(instr_cnt)
    );

    typedef struct packed {
        logic        rst, flush, es, ms, valid;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
    } in_t;

    typedef struct packed {
        logic        valid;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        whilo;
        logic [31:0] hi, lo;
        logic [63:0] hilo;
        logic [1:0]  cnt;
        logic [3:0]  ic;
    } out_t;

    typedef struct {
        in_t         i;
        logic        e_valid, e_wreg;
        logic [31:0] e_wdata;
        logic [63:0] e_hilo;
        logic [1:0]  e_cnt;
        logic [3:0]  e_ic;
    } vec_t;

    int   checks = 0;
    int   errors = 0;
    out_t model = '0;
    out_t exp_q[$];
    vec_t tbl[$];

    function automatic vec_t mk(logic r, logic f, logic es, logic ms, logic v, logic [4:0] wd,
                                logic wreg, logic [31:0] wdata, logic whilo, logic [31:0] hi,
                                logic [31:0] lo, logic [63:0] hilo, logic [1:0] cnt,
                                logic ev, logic ewreg, logic [31:0] ewdata, logic [63:0] ehilo,
                                logic [1:0] ecnt, logic [3:0] eic);
        vec_t t;
        t.i = '{rst: r, flush: f, es: es, ms: ms, valid: v, wd: wd, wreg: wreg, wdata: wdata,
                whilo: whilo, hi: hi, lo: lo, hilo: hilo, cnt: cnt};
        t.e_valid = ev; t.e_wreg = ewreg; t.e_wdata = ewdata;
        t.e_hilo = ehilo; t.e_cnt = ecnt; t.e_ic = eic;
        return t;
    endfunction

    function automatic out_t next_model(out_t cur, in_t v);
        out_t n = cur;
        if (v.rst) n = '0;
        else if (v.flush) begin
            n = '0;
            n.ic = cur.ic;
        end else if (v.ms) n = cur;
        else if (v.es) begin
            n = '0;
            n.hilo = v.hilo;
            n.cnt = v.cnt;
            n.ic = cur.ic;
        end else begin
            n.valid = v.valid; n.wd = v.wd; n.wreg = v.wreg; n.wdata = v.wdata;
            n.whilo = v.whilo; n.hi = v.hi; n.lo = v.lo;
            n.hilo = '0; n.cnt = '0;
            n.ic = cur.ic + (v.valid ? 4'd1 : 4'd0);
        end
        return n;
    endfunction

    function automatic out_t actual();
        return '{valid: mem_valid, wd: mem_wd, wreg: mem_wreg, wdata: mem_wdata,
                 whilo: mem_whilo, hi: mem_hi, lo: mem_lo, hilo: hilo_tmp_o,
                 cnt: cnt_o, ic: instr_cnt};
    endfunction

    task automatic step(input in_t v, input string name);
        out_t e, a;
        @(negedge clk);
        rst = v.rst; flush = v.flush; ex_stall = v.es; mem_stall = v.ms; ex_valid = v.valid;
        ex_wd = v.wd; ex_wreg = v.wreg; ex_wdata = v.wdata; ex_whilo = v.whilo;
        ex_hi = v.hi; ex_lo = v.lo; ex_hilo_tmp = v.hilo; ex_cnt = v.cnt;
        model = next_model(model, v);
        exp_q.push_back(model);
        @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = exp_q.pop_front();
            a = actual();
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got v=%0b wd=%0d wr=%0b wdata=%h whl=%0b hi=%h lo=%h tmp=%h cnt=%0d ic=%0d, expected v=%0b wd=%0d wr=%0b wdata=%h whl=%0b hi=%h lo=%h tmp=%h cnt=%0d ic=%0d",
                         name, a.valid, a.wd, a.wreg, a.wdata, a.whilo, a.hi, a.lo, a.hilo, a.cnt, a.ic,
                         e.valid, e.wd, e.wreg, e.wdata, e.whilo, e.hi, e.lo, e.hilo, e.cnt, e.ic);
            end
        end
    endtask

    function automatic in_t idle(logic valid);
        in_t v = '0;
        v.valid = valid;
        v.wd = 5'd9; v.wreg = valid; v.wdata = 32'hC0DE_0000 | 32'(valid);
        return v;
    endfunction

    localparam logic [63:0] TMP1 = 64'h0000_0001_FFFF_FFFE;
    localparam logic [63:0] TMP2 = 64'hAAAA_5555_0123_4567;

    initial begin
        rst = 1; flush = 0; ex_stall = 0; mem_stall = 0; ex_valid = 0; ex_wd = 0; ex_wreg = 0;
        ex_wdata = 0; ex_whilo = 0; ex_hi = 0; ex_lo = 0; ex_hilo_tmp = 0; ex_cnt = 0;

        // rst with random EX values
        tbl.push_back(mk(1,0,0,0,1,5'($urandom),1,$urandom,1,$urandom,$urandom,{$urandom,$urandom},2'($urandom), 0,0,0,0,0,0));
        tbl.push_back(mk(1,0,1,0,1,5'($urandom),1,$urandom,1,$urandom,$urandom,{$urandom,$urandom},2'($urandom), 0,0,0,0,0,0));
        // normal pass
        tbl.push_back(mk(0,0,0,0,1,5'd3,1,32'hDEADBEEF,1,32'h11,32'h22,64'h0,0, 1,1,32'hDEADBEEF,0,0,1));
        // bubble carrying madd partial product
        tbl.push_back(mk(0,0,1,0,1,5'd4,1,32'h55,1,32'h1,32'h2,TMP1,2'b01, 0,0,0,TMP1,1,1));
        // release stall, load 12345678
        tbl.push_back(mk(0,0,0,0,1,5'd7,1,32'h12345678,0,0,0,TMP2,2'b11, 1,1,32'h12345678,0,0,2));
        // hold for 3 cycles with new EX values
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0,0,1,1,1,5'(k+10),1,32'hFACE_0000+k,1,32'h9,32'h8,TMP2,2'b10, 1,1,32'h12345678,0,0,2));
        // bubble making tmp nonzero, then flush over both stalls
        tbl.push_back(mk(0,0,1,0,1,5'd1,1,32'h1,0,0,0,TMP2,2'b10, 0,0,0,TMP2,2,2));
        tbl.push_back(mk(0,1,1,1,1,5'd2,1,32'h2,1,32'h3,32'h4,TMP1,2'b01, 0,0,0,0,0,2));
        // normal load, then illegal mem_stall with ex_stall=0 drops payload
        tbl.push_back(mk(0,0,0,0,1,5'd6,1,32'hA5A5A5A5,1,32'h66,32'h77,0,0, 1,1,32'hA5A5A5A5,0,0,3));
        tbl.push_back(mk(0,0,0,1,1,5'd8,1,32'h99,1,32'h1,32'h1,TMP1,1, 1,1,32'hA5A5A5A5,0,0,3));
        // invalid slot still captured, counter unchanged
        tbl.push_back(mk(0,0,0,0,0,5'd5,0,32'h77,0,0,0,0,0, 0,0,32'h77,0,0,3));
        // rst mid-madd
        tbl.push_back(mk(0,0,1,0,1,5'd5,1,32'h5,1,0,0,TMP1,2'b01, 0,0,0,TMP1,1,3));
        tbl.push_back(mk(1,0,1,0,1,5'd5,1,32'h5,1,0,0,TMP2,2'b10, 0,0,0,0,0,0));

        for (int n = 0; n < tbl.size(); n++) begin
            step(tbl[n].i, $sformatf("vec%0d", n));
            checks++;
            if (mem_valid !== tbl[n].e_valid || mem_wreg !== tbl[n].e_wreg ||
                mem_wdata !== tbl[n].e_wdata || hilo_tmp_o !== tbl[n].e_hilo ||
                cnt_o !== tbl[n].e_cnt || instr_cnt !== tbl[n].e_ic) begin
                errors++;
                $display("FAIL tbl%0d: got v=%0b wr=%0b wdata=%h tmp=%h cnt=%0d ic=%0d, expected v=%0b wr=%0b wdata=%h tmp=%h cnt=%0d ic=%0d",
                         n, mem_valid, mem_wreg, mem_wdata, hilo_tmp_o, cnt_o, instr_cnt,
                         tbl[n].e_valid, tbl[n].e_wreg, tbl[n].e_wdata, tbl[n].e_hilo,
                         tbl[n].e_cnt, tbl[n].e_ic);
            end
        end

        // counter wrap: 17 valid then 3 invalid, starting from reset
        for (int k = 0; k < 17; k++) begin
            step(idle(1'b1), $sformatf("wrap_v%0d", k));
            if (k == 15) begin
                checks++;
                if (instr_cnt !== 4'd0) begin
                    errors++;
                    $display("FAIL wrap16: instr_cnt=%0d expected 0", instr_cnt);
                end
            end
        end
        for (int k = 0; k < 3; k++) step(idle(1'b0), $sformatf("wrap_i%0d", k));
        checks++;
        if (instr_cnt !== 4'd1) begin
            errors++;
            $display("FAIL wrap_end: instr_cnt=%0d expected 1", instr_cnt);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
